// File: rtl/motor_pwm_pkg.sv
// Shared types and default constants for the motor PWM ramp generator.
// The slew-limited soft start/stop is built only when MOTOR_PWM_RAMP_EN is defined.
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        RUN,
        FAULT
    } pwm_state_t;

    localparam int PWM_DUTY_W_DEF    = 12;
    localparam int PWM_CNT_W_DEF     = 13;
    localparam int PWM_PERIOD_DEF    = 5611;
    localparam int PWM_OFFSET_DEF    = 1514;
    localparam int PWM_RAMP_STEP_DEF = 64;

endpackage

// File: rtl/motor_pwm_ramp_generator_if.sv
// Command/status bundle between the accelerometer filter side and the PWM generator.
// The master side drives commands; the slave side is the generator.
interface motor_pwm_ramp_generator_if #(
    parameter int DUTY_W = 12
);
    logic              enable;
    logic [DUTY_W-1:0] PWMinput;
    logic              fault_in;
    logic              fault_clr;
    logic              PWMout;
    logic              period_start;
    logic [DUTY_W-1:0] duty_applied;
    logic              fault_latched;

    modport master (
        output enable, PWMinput, fault_in, fault_clr,
        input  PWMout, period_start, duty_applied, fault_latched
    );

    modport slave (
        input  enable, PWMinput, fault_in, fault_clr,
        output PWMout, period_start, duty_applied, fault_latched
    );
endinterface

// File: rtl/pwm_slew_limiter.sv
// Applied-duty register that moves toward target on each update strobe.
// With MOTOR_PWM_RAMP_EN the move is limited to 'step'; otherwise it jumps to target.
module pwm_slew_limiter #(
    parameter int DUTY_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              upd,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] step,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] duty_nxt
);

`ifdef MOTOR_PWM_RAMP_EN
    logic [DUTY_W-1:0] diff;

    always_comb begin
        diff     = '0;
        duty_nxt = target;
        if (target > duty) begin
            diff = target - duty;
            if (diff > step) duty_nxt = duty + step;
        end else begin
            diff = duty - target;
            if (diff > step) duty_nxt = duty - step;
        end
    end
`else
    logic unused_step;
    assign unused_step = ^step;
    assign duty_nxt    = target;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   duty <= '0;
        else if (clr) duty <= '0;
        else if (upd) duty <= duty_nxt;
    end

endmodule

// File: rtl/motor_pwm_ramp_generator.sv
// Motor PWM with shadowed duty, start-of-motion floor offset, enable and latched fault.
// Soft start/stop slew limiting is compiled in by defining MOTOR_PWM_RAMP_EN.
module motor_pwm_ramp_generator
    import motor_pwm_pkg::*;
#(
    parameter int DUTY_W    = PWM_DUTY_W_DEF,
    parameter int CNT_W     = PWM_CNT_W_DEF,
    parameter int PERIOD    = PWM_PERIOD_DEF,
    parameter int OFFSET    = PWM_OFFSET_DEF,
    parameter int RAMP_STEP = PWM_RAMP_STEP_DEF
) (
    input logic                       PWMClock,
    input logic                       PWMReset_n,
    motor_pwm_ramp_generator_if.slave bus
);

    // Wide enough for both duty+OFFSET and the counter without overflow.
    localparam int SW = ((DUTY_W > CNT_W) ? DUTY_W : CNT_W) + 1;
    localparam logic [SW-1:0]     PERIOD_S = SW'(PERIOD);
    localparam logic [SW-1:0]     OFF_S    = SW'(OFFSET);
    localparam logic [SW-1:0]     CAP_S    = SW'(PERIOD - OFFSET);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);

    pwm_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              at_end;
    logic [DUTY_W-1:0] target, tgt_in;
    logic [DUTY_W-1:0] duty, duty_nxt;
    logic [SW-1:0]     sum, cmp;
    logic              clr, upd, active_nxt;
    logic              pwm_q, ps_q;

    assign at_end = (cnt == CNT_LAST);
    assign tgt_in = (SW'(bus.PWMinput) > CAP_S) ? CAP_S[DUTY_W-1:0] : bus.PWMinput;

    // Zero duty stays fully off; the floor only lifts a nonzero command.
    assign sum = SW'(duty) + OFF_S;
    assign cmp = (duty == '0) ? '0 : ((sum > PERIOD_S) ? PERIOD_S : sum);

    pwm_slew_limiter #(.DUTY_W(DUTY_W)) u_slew (
        .clk      (PWMClock),
        .rst_n    (PWMReset_n),
        .clr      (clr),
        .upd      (upd),
        .target   (target),
        .step     (DUTY_W'(RAMP_STEP)),
        .duty     (duty),
        .duty_nxt (duty_nxt)
    );

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        upd       = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
`ifdef MOTOR_PWM_RAMP_EN
                if (bus.enable) state_nxt = RAMP;
`else
                if (bus.enable) state_nxt = RUN;
`endif
            end
            RAMP, RUN: begin
                if (!bus.enable) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end else if (at_end) begin
                    upd = 1'b1;
`ifdef MOTOR_PWM_RAMP_EN
                    state_nxt = (duty_nxt == tgt_in) ? RUN : RAMP;
`else
                    state_nxt = RUN;
`endif
                end
            end
            FAULT: begin
                clr = 1'b1;
                if (bus.fault_clr && !bus.fault_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Fault overrides enable changes and the boundary update alike.
        if (bus.fault_in) begin
            state_nxt = FAULT;
            clr       = 1'b1;
            upd       = 1'b0;
        end
    end

    assign active_nxt = (state_nxt == RAMP) || (state_nxt == RUN);

    always_ff @(posedge PWMClock or negedge PWMReset_n) begin
        if (!PWMReset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= '0;
            pwm_q  <= 1'b0;
            ps_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= at_end ? '0 : cnt + 1'b1;
            ps_q   <= at_end;
            if (at_end) target <= tgt_in;
            // Gate on next state so a fault or disable kills the output at this edge.
            pwm_q  <= active_nxt && (SW'(cnt) < cmp);
        end
    end

    assign bus.PWMout        = pwm_q;
    assign bus.period_start  = ps_q;
    assign bus.duty_applied  = duty;
    assign bus.fault_latched = (state == FAULT);

endmodule

// File: tb/tb_motor_pwm_ramp_generator.sv
// Scoreboard bench for motor_pwm_ramp_generator on a scaled-down period.
// Expected tables follow MOTOR_PWM_RAMP_EN the same way the RTL does.
module tb_motor_pwm_ramp_generator;

    localparam int P    = 100;
    localparam int OFF  = 27;
    localparam int STEP = 8;
    localparam int DW   = 7;
    localparam int CW   = 7;

    logic PWMClock   = 1'b0;
    logic PWMReset_n = 1'b0;
    always #5 PWMClock = ~PWMClock;

    motor_pwm_ramp_generator_if #(.DUTY_W(DW)) bus ();

    motor_pwm_ramp_generator #(
        .DUTY_W(DW), .CNT_W(CW), .PERIOD(P), .OFFSET(OFF), .RAMP_STEP(STEP)
    ) dut (
        .PWMClock   (PWMClock),
        .PWMReset_n (PWMReset_n),
        .bus        (bus)
    );

    // One record per period start: duty now in effect, high clocks of the period just ended.
    typedef struct {
        int duty;
        int hi;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int h);
        exp_t e;
        e.duty = d;
        e.hi   = h;
        q.push_back(e);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (q.size() > 0 && n < lim) begin
            @(negedge PWMClock);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d records left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge PWMClock);
    endtask

    // Monitor: integrates PWMout per period and checks each period start.
    initial begin
        int   hi   = 0;
        int   gap  = 0;
        bit   have = 0;
        exp_t e;
        forever begin
            @(negedge PWMClock);
            if (!PWMReset_n) begin
                hi   = 0;
                gap  = 0;
                have = 0;
            end else begin
                gap++;
                hi += int'(bus.PWMout);
                if (bus.period_start) begin
                    if (have) chk("period_gap", gap, P);
                    have = 1;
                    gap  = 0;
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("duty_applied", int'(bus.duty_applied), e.duty);
                        if (e.hi >= 0) chk("high_time", hi, e.hi);
                    end
                    hi = 0;
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.enable    = 1'b1;
        bus.PWMinput  = 7'd40;
        bus.fault_in  = 1'b0;
        bus.fault_clr = 1'b0;
        settle(3);
        chk("rst_pwmout", int'(bus.PWMout), 0);
        chk("rst_period_start", int'(bus.period_start), 0);
        chk("rst_duty", int'(bus.duty_applied), 0);
        chk("rst_fault", int'(bus.fault_latched), 0);

        // Soft start from reset toward 40.
`ifdef MOTOR_PWM_RAMP_EN
        push(0, 0); push(8, 0); push(16, 35); push(24, 43);
        push(32, 51); push(40, 59); push(40, 67);
`else
        push(0, 0); push(40, 0); push(40, 67);
`endif
        PWMReset_n = 1'b1;
        drain(1500);

        // Mid-period command change: current period untouched, applied next-but-one.
        settle(10);
        bus.PWMinput = 7'd45;
        push(40, 67); push(45, 67); push(45, 72);
        drain(500);

        // 127 clamps to PERIOD-OFFSET=73; compare saturates at 100% high.
        settle(10);
        bus.PWMinput = 7'd127;
`ifdef MOTOR_PWM_RAMP_EN
        push(45, 72); push(53, 72); push(61, 80); push(69, 88);
        push(73, 96); push(73, 100);
`else
        push(45, 72); push(73, 72); push(73, 100);
`endif
        drain(1000);

        // Lower target.
        settle(10);
        bus.PWMinput = 7'd60;
`ifdef MOTOR_PWM_RAMP_EN
        push(73, 100); push(65, 100); push(60, 92); push(60, 87);
`else
        push(73, 100); push(60, 100); push(60, 87);
`endif
        drain(700);

        // Disable mid-high-time: immediate off, no ramp down; then zero command.
        settle(10);
        chk("pwm_before_disable", int'(bus.PWMout), 1);
        bus.enable   = 1'b0;
        bus.PWMinput = 7'd0;
        push(0, -1);
        @(negedge PWMClock);
        chk("pwm_disabled", int'(bus.PWMout), 0);
        chk("duty_disabled", int'(bus.duty_applied), 0);
        drain(300);
        bus.enable = 1'b1;
        push(0, 0); push(0, 0);
        drain(400);

        // Ramp up again, then fault mid-high-time.
        settle(10);
        bus.PWMinput = 7'd40;
`ifdef MOTOR_PWM_RAMP_EN
        push(0, 0); push(8, 0); push(16, 35); push(24, 43);
        push(32, 51); push(40, 59); push(40, 67);
`else
        push(0, 0); push(40, 0); push(40, 67);
`endif
        drain(1500);
        settle(30);
        chk("pwm_before_fault", int'(bus.PWMout), 1);
        bus.fault_in = 1'b1;
        @(negedge PWMClock);
        chk("pwm_fault", int'(bus.PWMout), 0);
        chk("fault_latched_set", int'(bus.fault_latched), 1);
        chk("duty_fault", int'(bus.duty_applied), 0);
        bus.fault_clr = 1'b1;
        @(negedge PWMClock);
        bus.fault_clr = 1'b0;
        bus.fault_in  = 1'b0;
        @(negedge PWMClock);
        chk("fault_clr_ignored", int'(bus.fault_latched), 1);
        bus.fault_clr = 1'b1;
        @(negedge PWMClock);
        bus.fault_clr = 1'b0;
        chk("fault_cleared", int'(bus.fault_latched), 0);
        chk("duty_after_clear", int'(bus.duty_applied), 0);
`ifdef MOTOR_PWM_RAMP_EN
        push(8, -1); push(16, 35);
`else
        push(40, -1); push(40, 67);
`endif
        drain(400);

        // Asynchronous reset in the high time, between clock edges.
        settle(10);
        chk("pwm_before_reset", int'(bus.PWMout), 1);
        #2;
        PWMReset_n = 1'b0;
        #1;
        chk("async_rst_pwmout", int'(bus.PWMout), 0);
        chk("async_rst_period_start", int'(bus.period_start), 0);
        chk("async_rst_duty", int'(bus.duty_applied), 0);
        chk("async_rst_fault", int'(bus.fault_latched), 0);
        @(negedge PWMClock);
        PWMReset_n = 1'b1;
        n = 0;
        do begin
            @(negedge PWMClock);
            n++;
        end while (!bus.period_start && n < 3 * P);
        chk("restart_first_period", n, P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
